// File: rtl/mem2io_pkg.sv
// mem2io_pkg: shared state encoding and address constants for mem2io_bridge
package mem2io_pkg;
    typedef enum logic [2:0] {IDLE, IO, SETUP, WAIT, DONE} m2io_state_t;
    localparam logic [15:0] DEF_IO_ADDR = 16'hFFFF;
    localparam int LED_ADDR_OFFSET = 1;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: parametrised-width two-flop synchroniser with async active-low reset
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/mem2io_bridge.sv
// mem2io_bridge: Req/Ack bridge from the CPU to SRAM with wait states plus switch/hex I/O.
// Define MEM2IO_LED_REG_EN to add the LED register at IO_ADDR-1.
module mem2io_bridge
    import mem2io_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                SW_W        = 10,
    parameter int                HEX_DIGITS  = 4,
    parameter int                WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(DEF_IO_ADDR)
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Req,
    input  logic                    Wr,
    input  logic [ADDR_W-1:0]       Addr,
    input  logic [DATA_W-1:0]       Wdata,
    output logic [DATA_W-1:0]       Rdata,
    output logic                    Ack,
    output logic                    Busy,
    input  logic [SW_W-1:0]         Switches,
    output logic [HEX_DIGITS*4-1:0] Hex,
    output logic [DATA_W-1:0]       LED,
    output logic [ADDR_W-1:0]       SRAM_ADDR,
    output logic [DATA_W-1:0]       SRAM_DQ_out,
    input  logic [DATA_W-1:0]       SRAM_DQ_in,
    output logic                    SRAM_OE_n,
    output logic                    SRAM_WE_n
);
`ifdef MEM2IO_LED_REG_EN
    localparam bit LED_EN = 1'b1;
`else
    localparam bit LED_EN = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] LED_ADDR = IO_ADDR - ADDR_W'(LED_ADDR_OFFSET);

    m2io_state_t       state, next_state;
    logic              wr_q, wr_c, io_hit, led_hit, strobe, ack_d, oe_n_d, we_n_d;
    logic [3:0]        cnt;
    logic [SW_W-1:0]   sw_sync;
    logic [DATA_W-1:0] led_q;

    sync_2ff #(.W(SW_W)) u_sync (.clk(Clk), .rst_n(Reset), .d(Switches), .q(sw_sync));

    assign led_hit = LED_EN && (Addr == LED_ADDR);
    assign io_hit  = (Addr == IO_ADDR) || led_hit;
    assign wr_c    = (state == IDLE) ? Wr : wr_q;
    assign Busy    = state != IDLE;
    assign LED     = LED_EN ? led_q : '0;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (Req) next_state = io_hit ? IO : SETUP;
            SETUP:    next_state = (WAIT_STATES > 0) ? WAIT : DONE;
            WAIT:     if (cnt == 4'd1) next_state = DONE;
            default:  next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state so the registered strobes line up with the state they belong to.
    always_comb begin
        strobe = (next_state == SETUP) || (next_state == WAIT);
        ack_d  = (next_state == IO) || (next_state == DONE);
        oe_n_d = !(strobe && !wr_c);
        we_n_d = !(strobe && wr_c);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Rdata       <= '0;
            Ack         <= 1'b0;
            Hex         <= '0;
            led_q       <= '0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
            SRAM_OE_n   <= 1'b1;
            SRAM_WE_n   <= 1'b1;
            cnt         <= '0;
            wr_q        <= 1'b0;
        end else begin
            Ack       <= ack_d;
            SRAM_OE_n <= oe_n_d;
            SRAM_WE_n <= we_n_d;
            if (state == IDLE && Req) begin
                wr_q <= Wr;
                if (io_hit) begin
                    if (!Wr)          Rdata <= led_hit ? led_q : DATA_W'(sw_sync);
                    else if (led_hit) led_q <= Wdata;
                    else              Hex   <= Wdata[HEX_DIGITS*4-1:0];
                end else begin
                    SRAM_ADDR   <= Addr;
                    SRAM_DQ_out <= Wdata;
                    cnt         <= 4'(WAIT_STATES);
                end
            end
            if (state == WAIT) cnt <= cnt - 4'd1;
            // Capture on the last strobed cycle, while OE_n is still low.
            if (next_state == DONE && !wr_q) Rdata <= SRAM_DQ_in;
        end
    end
endmodule

// File: tb/tb_mem2io_bridge.sv
// tb_mem2io_bridge: scoreboard bench for mem2io_bridge (WAIT_STATES=2 main instance, WAIT_STATES=0 second instance)
module tb_mem2io_bridge;
    logic        Clk = 0, Reset = 0, Req = 0, Wr = 0, req0 = 0;
    logic [15:0] Addr = 0, Wdata = 0, SRAM_DQ_in = 0;
    logic [9:0]  Switches = 0;
    logic [15:0] Rdata, Hex, LED, SRAM_ADDR, SRAM_DQ_out;
    logic        Ack, Busy, SRAM_OE_n, SRAM_WE_n;
    logic [15:0] Rdata0, Hex0, LED0, SRAM_ADDR0, SRAM_DQ_out0;
    logic        Ack0, Busy0, SRAM_OE_n0, SRAM_WE_n0;

    int          passed = 0, total = 0;
    logic [15:0] exp_q[$];
    int          lat, oe_lo, we_lo, both_lo;
    logic [15:0] rd, ex;

    mem2io_bridge #(.WAIT_STATES(2)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Addr(Addr), .Wdata(Wdata),
        .Rdata(Rdata), .Ack(Ack), .Busy(Busy), .Switches(Switches), .Hex(Hex), .LED(LED),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_in(SRAM_DQ_in),
        .SRAM_OE_n(SRAM_OE_n), .SRAM_WE_n(SRAM_WE_n)
    );

    mem2io_bridge #(.WAIT_STATES(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Req(req0), .Wr(Wr), .Addr(Addr), .Wdata(Wdata),
        .Rdata(Rdata0), .Ack(Ack0), .Busy(Busy0), .Switches(Switches), .Hex(Hex0), .LED(LED0),
        .SRAM_ADDR(SRAM_ADDR0), .SRAM_DQ_out(SRAM_DQ_out0), .SRAM_DQ_in(SRAM_DQ_in),
        .SRAM_OE_n(SRAM_OE_n0), .SRAM_WE_n(SRAM_WE_n0)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] d, input logic [15:0] e);
        @(negedge Clk);
        Req = 1; Wr = wr; Addr = a; Wdata = d;
        if (!wr) exp_q.push_back(e);
        lat = 0; oe_lo = 0; we_lo = 0; both_lo = 0;
        do begin
            @(negedge Clk);
            lat++;
            oe_lo   += int'(!SRAM_OE_n);
            we_lo   += int'(!SRAM_WE_n);
            both_lo += int'(!SRAM_OE_n && !SRAM_WE_n);
        end while (!Ack && lat < 30);
        Req = 0;
        rd = Rdata;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge Clk);
        total++; if ({Rdata, Ack, Busy, Hex, LED} !== 50'd0) $display("FAIL reset_regs: got %h expected 0", {Rdata, Ack, Busy, Hex, LED}); else passed++;
        total++; if ({SRAM_ADDR, SRAM_DQ_out} !== 32'd0) $display("FAIL reset_sram_bus: got %h expected 0", {SRAM_ADDR, SRAM_DQ_out}); else passed++;
        total++; if ({SRAM_OE_n, SRAM_WE_n, SRAM_OE_n0, SRAM_WE_n0} !== 4'hF) $display("FAIL reset_strobes: got %b expected 1111", {SRAM_OE_n, SRAM_WE_n, SRAM_OE_n0, SRAM_WE_n0}); else passed++;
        @(negedge Clk) Reset = 1;
        @(negedge Clk);
    endtask

    task automatic test_sram_read;
        SRAM_DQ_in = 16'hBEEF;
        access(0, 16'h0040, 16'h0000, 16'hBEEF);
        total++; if (lat !== 4) $display("FAIL sram_rd_latency: got %0d expected 4", lat); else passed++;
        total++; if (oe_lo !== 3) $display("FAIL sram_rd_oe_cycles: got %0d expected 3", oe_lo); else passed++;
        total++; if (we_lo !== 0) $display("FAIL sram_rd_we_cycles: got %0d expected 0", we_lo); else passed++;
        ex = exp_q.size() ? exp_q.pop_front() : 16'hxxxx;
        total++; if (rd !== ex) $display("FAIL sram_rd_data: got %h expected %h", rd, ex); else passed++;
        total++; if (SRAM_ADDR !== 16'h0040) $display("FAIL sram_rd_addr: got %h expected 0040", SRAM_ADDR); else passed++;
        @(negedge Clk);
        total++; if (Ack !== 1'b0) $display("FAIL sram_rd_ack_pulse: got %b expected 0", Ack); else passed++;
        SRAM_DQ_in = 16'h0000;
        repeat (3) @(negedge Clk);
        total++; if (Rdata !== 16'hBEEF) $display("FAIL sram_rd_hold: got %h expected beef", Rdata); else passed++;
    endtask

    task automatic test_ws0_write;
        int l, w, o;
        logic [15:0] dq;
        @(negedge Clk);
        req0 = 1; Wr = 1; Addr = 16'h0010; Wdata = 16'h1234;
        l = 0; w = 0; o = 0; dq = 0;
        do begin
            @(negedge Clk);
            l++;
            if (!SRAM_WE_n0) begin w++; dq = SRAM_DQ_out0; end
            o += int'(!SRAM_OE_n0);
        end while (!Ack0 && l < 20);
        req0 = 0;
        total++; if (l !== 2) $display("FAIL ws0_wr_latency: got %0d expected 2", l); else passed++;
        total++; if (w !== 1) $display("FAIL ws0_wr_we_cycles: got %0d expected 1", w); else passed++;
        total++; if (o !== 0) $display("FAIL ws0_wr_oe_cycles: got %0d expected 0", o); else passed++;
        total++; if (dq !== 16'h1234) $display("FAIL ws0_wr_data: got %h expected 1234", dq); else passed++;
        total++; if (SRAM_ADDR0 !== 16'h0010) $display("FAIL ws0_wr_addr: got %h expected 0010", SRAM_ADDR0); else passed++;
    endtask

    task automatic test_switch_read;
        Switches = 10'h2A5;
        repeat (3) @(negedge Clk);
        access(0, 16'hFFFF, 16'h0000, 16'h02A5);
        total++; if (lat !== 1) $display("FAIL sw_rd_latency: got %0d expected 1", lat); else passed++;
        ex = exp_q.size() ? exp_q.pop_front() : 16'hxxxx;
        total++; if (rd !== ex) $display("FAIL sw_rd_data: got %h expected %h", rd, ex); else passed++;
        total++; if (oe_lo + we_lo !== 0) $display("FAIL sw_rd_strobes: got %0d expected 0", oe_lo + we_lo); else passed++;
    endtask

    task automatic test_hex_write;
        access(1, 16'hFFFF, 16'hCAFE, 16'h0000);
        total++; if (lat !== 1) $display("FAIL hex_wr_latency: got %0d expected 1", lat); else passed++;
        total++; if (Hex !== 16'hCAFE) $display("FAIL hex_wr_value: got %h expected cafe", Hex); else passed++;
        total++; if (oe_lo + we_lo !== 0) $display("FAIL hex_wr_strobes: got %0d expected 0", oe_lo + we_lo); else passed++;
    endtask

    task automatic test_busy_ignore;
        int acks = 0;
        @(negedge Clk);
        Req = 1; Wr = 1; Addr = 16'h0020; Wdata = 16'h7777;
        @(negedge Clk);
        Req = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            acks += int'(Ack);
            if (i == 0 || i == 2) begin Req = 1; Wr = 1; Addr = 16'hFFFF; Wdata = 16'h1111; end
            else Req = 0;
        end
        total++; if (acks !== 1) $display("FAIL busy_ack_count: got %0d expected 1", acks); else passed++;
        total++; if (Hex !== 16'hCAFE) $display("FAIL busy_hex_unchanged: got %h expected cafe", Hex); else passed++;
        total++; if (SRAM_ADDR !== 16'h0020) $display("FAIL busy_sram_addr: got %h expected 0020", SRAM_ADDR); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [3:0] pat = 0;
        @(negedge Clk);
        Req = 1; Wr = 0; Addr = 16'hFFFF;
        exp_q.push_back(16'h02A5);
        exp_q.push_back(16'h02A5);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            pat = {pat[2:0], Ack};
            if (Ack) begin
                ex = exp_q.size() ? exp_q.pop_front() : 16'hxxxx;
                total++; if (Rdata !== ex) $display("FAIL b2b_data: got %h expected %h", Rdata, ex); else passed++;
            end
        end
        Req = 0;
        total++; if (pat !== 4'b1010) $display("FAIL b2b_ack_pattern: got %b expected 1010", pat); else passed++;
        total++; if (exp_q.size() !== 0) $display("FAIL b2b_scoreboard_left: got %0d expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_led;
`ifdef MEM2IO_LED_REG_EN
        access(1, 16'hFFFE, 16'h00FF, 16'h0000);
        total++; if (lat !== 1) $display("FAIL led_wr_latency: got %0d expected 1", lat); else passed++;
        total++; if (LED !== 16'h00FF) $display("FAIL led_value: got %h expected 00ff", LED); else passed++;
        access(0, 16'hFFFE, 16'h0000, 16'h00FF);
        total++; if (lat !== 1) $display("FAIL led_rd_latency: got %0d expected 1", lat); else passed++;
`else
        access(1, 16'hFFFE, 16'h00FF, 16'h0000);
        total++; if (lat !== 4) $display("FAIL led_sram_wr_latency: got %0d expected 4", lat); else passed++;
        total++; if (we_lo !== 3) $display("FAIL led_sram_we_cycles: got %0d expected 3", we_lo); else passed++;
        total++; if (LED !== 16'h0000) $display("FAIL led_value: got %h expected 0000", LED); else passed++;
        total++; if (SRAM_ADDR !== 16'hFFFE) $display("FAIL led_sram_addr: got %h expected fffe", SRAM_ADDR); else passed++;
        SRAM_DQ_in = 16'h5A5A;
        access(0, 16'hFFFE, 16'h0000, 16'h5A5A);
        total++; if (lat !== 4) $display("FAIL led_sram_rd_latency: got %0d expected 4", lat); else passed++;
`endif
        ex = exp_q.size() ? exp_q.pop_front() : 16'hxxxx;
        total++; if (rd !== ex) $display("FAIL led_rd_data: got %h expected %h", rd, ex); else passed++;
        total++; if (both_lo !== 0) $display("FAIL led_both_strobes: got %0d expected 0", both_lo); else passed++;
    endtask

    task automatic test_reset_mid;
        int acks = 0;
        @(negedge Clk);
        Req = 1; Wr = 1; Addr = 16'h0030; Wdata = 16'h9999;
        @(negedge Clk);
        Req = 0;
        @(negedge Clk);
        total++; if (SRAM_WE_n !== 1'b0) $display("FAIL rstmid_we_before: got %b expected 0", SRAM_WE_n); else passed++;
        #2 Reset = 0;
        #1;
        total++; if (SRAM_WE_n !== 1'b1) $display("FAIL rstmid_we_async: got %b expected 1", SRAM_WE_n); else passed++;
        total++; if (Busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", Busy); else passed++;
        repeat (4) begin
            @(negedge Clk);
            acks += int'(Ack);
        end
        total++; if (acks !== 0) $display("FAIL rstmid_no_ack: got %0d expected 0", acks); else passed++;
        total++; if ({Hex, LED} !== 32'd0) $display("FAIL rstmid_hex_led: got %h expected 0", {Hex, LED}); else passed++;
        Reset = 1;
        SRAM_DQ_in = 16'h1357;
        access(0, 16'h0041, 16'h0000, 16'h1357);
        ex = exp_q.size() ? exp_q.pop_front() : 16'hxxxx;
        total++; if (rd !== ex || lat !== 4) $display("FAIL rstmid_recover: got %h/%0d expected %h/4", rd, lat, ex); else passed++;
    endtask

    initial begin
        test_reset;
        test_sram_read;
        test_ws0_write;
        test_switch_read;
        test_hex_write;
        test_busy_ignore;
        test_back_to_back;
        test_led;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
